// File: rtl/store_sequencer.sv
// Store sequencer: lane-aligns SB/SH/SW store data, builds byte enables and
// issues one or two word-aligned write beats on the data-memory port.
module store_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_req_valid,
  output logic                  O_req_ready,
  input  logic [1:0]            I_storesel,
  input  logic [ADDR_WIDTH-1:0] I_addr,
  input  logic [31:0]           I_data,
  output logic                  O_mem_valid,
  input  logic                  I_mem_ready,
  output logic [ADDR_WIDTH-1:0] O_mem_addr,
  output logic [31:0]           O_mem_wdata,
  output logic [3:0]            O_mem_be,
  output logic                  O_busy,
  output logic                  O_done,
  output logic                  O_misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

  localparam logic [ADDR_WIDTH-3:0] WORD_ONE = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_done;
  logic                  r_misaligned;
  logic [ADDR_WIDTH-3:0] r_waddr;
  logic [63:0]           r_sdata;
  logic [7:0]            r_be;

  logic                  w_done_nxt;
  logic                  w_mis_nxt;
  logic                  w_load;
  logic                  w_split;
  logic [63:0]           w_sdata;
  logic [7:0]            w_be;
  logic [ADDR_WIDTH-3:0] w_waddr_inc;

  function automatic logic [7:0] f_width_mask(input logic [1:0] sel);
    case (sel)
      2'b00:   f_width_mask = 8'h01;
      2'b01:   f_width_mask = 8'h03;
      default: f_width_mask = 8'h0F;
    endcase
  endfunction

  function automatic logic [31:0] f_mask_data(input logic [1:0] sel, input logic [31:0] data);
    case (sel)
      2'b00:   f_mask_data = {24'h0, data[7:0]};
      2'b01:   f_mask_data = {16'h0, data[15:0]};
      default: f_mask_data = data;
    endcase
  endfunction

  // Lane alignment over a 64-bit window; the upper half is the second beat.
  always_comb begin
    w_sdata = {32'h0, f_mask_data(I_storesel, I_data)} << {I_addr[1:0], 3'b000};
    w_be    = f_width_mask(I_storesel) << I_addr[1:0];
    w_split = |w_be[7:4];
  end

  assign w_waddr_inc = r_waddr + WORD_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_mis_nxt   = 1'b0;
    w_load      = 1'b0;
    O_req_ready = 1'b0;
    O_mem_valid = 1'b0;
    O_mem_addr  = '0;
    O_mem_wdata = '0;
    O_mem_be    = '0;
    O_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        O_req_ready = 1'b1;
        O_busy      = 1'b0;
        if (I_req_valid) begin
          if (w_split && (ALLOW_MISALIGNED == 1'b0)) begin
            w_mis_nxt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_BEAT0;
          end
        end
      end
      S_BEAT0: begin
        O_mem_valid = 1'b1;
        O_mem_addr  = {r_waddr, 2'b00};
        O_mem_wdata = r_sdata[31:0];
        O_mem_be    = r_be[3:0];
        if (I_mem_ready) begin
          if (|r_be[7:4]) begin
            w_state_nxt = S_BEAT1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        O_mem_valid = 1'b1;
        O_mem_addr  = {w_waddr_inc, 2'b00};
        O_mem_wdata = r_sdata[63:32];
        O_mem_be    = r_be[7:4];
        if (I_mem_ready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_done       <= w_done_nxt;
      r_misaligned <= w_mis_nxt;
    end
  end

  // Payload is only observed in BEAT states, so it carries no reset.
  always_ff @(posedge I_clk) begin
    if (w_load) begin
      r_waddr <= I_addr[ADDR_WIDTH-1:2];
      r_sdata <= w_sdata;
      r_be    <= w_be;
    end
  end

  assign O_done       = r_done;
  assign O_misaligned = r_misaligned;

endmodule

// File: tb/tb_store_sequencer.sv
// Randomized self-checking bench for store_sequencer; expected beats come from
// a byte-by-byte address model rather than the shift-based datapath.
module tb_store_sequencer;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, mem_valid, mem_ready, busy, done, mis;
  logic [1:0]  storesel;
  logic [31:0] addr, data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        nm_req_valid, nm_req_ready, nm_mem_valid, nm_mem_ready, nm_busy, nm_done, nm_mis;
  logic [1:0]  nm_storesel;
  logic [31:0] nm_addr, nm_data, nm_mem_addr, nm_mem_wdata;
  logic [3:0]  nm_mem_be;

  int pass_cnt;
  int total_cnt;

  int          exp_n;
  logic [31:0] exp_addr[2];
  logic [31:0] exp_wdata[2];
  logic [3:0]  exp_be[2];

  store_sequencer #(.ALLOW_MISALIGNED(1'b1), .ADDR_WIDTH(32)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_req_valid(req_valid), .O_req_ready(req_ready),
    .I_storesel(storesel), .I_addr(addr), .I_data(data),
    .O_mem_valid(mem_valid), .I_mem_ready(mem_ready),
    .O_mem_addr(mem_addr), .O_mem_wdata(mem_wdata), .O_mem_be(mem_be),
    .O_busy(busy), .O_done(done), .O_misaligned(mis)
  );

  store_sequencer #(.ALLOW_MISALIGNED(1'b0), .ADDR_WIDTH(32)) dut_nm (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_req_valid(nm_req_valid), .O_req_ready(nm_req_ready),
    .I_storesel(nm_storesel), .I_addr(nm_addr), .I_data(nm_data),
    .O_mem_valid(nm_mem_valid), .I_mem_ready(nm_mem_ready),
    .O_mem_addr(nm_mem_addr), .O_mem_wdata(nm_mem_wdata), .O_mem_be(nm_mem_be),
    .O_busy(nm_busy), .O_done(nm_done), .O_misaligned(nm_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: place each stored byte at its own byte address and group by word.
  task automatic model_store(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
    int          nbytes;
    int          b;
    logic [31:0] ba;
    logic [1:0]  lane;
    nbytes = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
    exp_n = 1;
    exp_addr[0] = a & ~32'h3;
    exp_addr[1] = exp_addr[0] + 32'd4;
    for (int k = 0; k < 2; k++) begin
      exp_wdata[k] = '0;
      exp_be[k]    = '0;
    end
    for (int i = 0; i < nbytes; i++) begin
      ba   = a + i;
      lane = ba[1:0];
      b    = ((ba & ~32'h3) == exp_addr[0]) ? 0 : 1;
      if (b == 1) exp_n = 2;
      exp_wdata[b][lane*8 +: 8] = d[i*8 +: 8];
      exp_be[b][lane] = 1'b1;
    end
  endtask

  task automatic do_store(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                          input int stall, input string tag);
    int st;
    model_store(sel, a, d);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL %s ready: got %b want 1", tag, req_ready);
    else pass_cnt++;
    req_valid = 1'b1; storesel = sel; addr = a; data = d;
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b < exp_n; b++) begin
      st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int j = 0; j <= st; j++) begin
        total_cnt++;
        if ({mem_valid, mem_addr, mem_wdata, mem_be, done, busy, req_ready} !==
            {1'b1, exp_addr[b], exp_wdata[b], exp_be[b], 1'b0, 1'b1, 1'b0})
          $display("FAIL %s beat%0d cyc%0d: got v=%b a=%h d=%h be=%b done=%b busy=%b rdy=%b want v=1 a=%h d=%h be=%b done=0 busy=1 rdy=0",
                   tag, b, j, mem_valid, mem_addr, mem_wdata, mem_be, done, busy, req_ready,
                   exp_addr[b], exp_wdata[b], exp_be[b]);
        else pass_cnt++;
        mem_ready = (j == st);
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    total_cnt++;
    if ({mem_valid, done, busy, req_ready} !== 4'b0101)
      $display("FAIL %s done: got v=%b done=%b busy=%b rdy=%b want 0 1 0 1", tag, mem_valid, done, busy, req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem_valid, done} !== 2'b00)
      $display("FAIL %s done_pulse: got v=%b done=%b want 0 0", tag, mem_valid, done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be, done, mis, busy} !== '0)
      $display("FAIL reset_outs: got v=%b a=%h d=%h be=%b done=%b mis=%b busy=%b want all 0",
               mem_valid, mem_addr, mem_wdata, mem_be, done, mis, busy);
    else pass_cnt++;
    total_cnt++;
    if ({nm_mem_valid, nm_mem_addr, nm_mem_wdata, nm_mem_be, nm_done, nm_mis, nm_busy} !== '0)
      $display("FAIL reset_outs_nm: got v=%b a=%h be=%b done=%b mis=%b", nm_mem_valid, nm_mem_addr, nm_mem_be, nm_done, nm_mis);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({req_ready, nm_req_ready, busy} !== 3'b110)
      $display("FAIL reset_release: got rdy=%b nm_rdy=%b busy=%b want 1 1 0", req_ready, nm_req_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    do_store(2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0, "sb_lane3");
    do_store(2'b10, 32'h0000_2000, 32'h1122_3344, 3, "sw_stall");
    do_store(2'b10, 32'h0000_1002, 32'h1122_3344, 0, "sw_split");
    do_store(2'b01, 32'hFFFF_FFFF, 32'h1234_BEEF, 1, "sh_wrap");
  endtask

  task automatic test_random();
    logic [1:0]  sel;
    logic [31:0] a, d;
    for (int i = 0; i < 40; i++) begin
      sel = 2'($urandom_range(0, 3));
      a   = $urandom;
      if (i % 4 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      d   = $urandom;
      do_store(sel, a, d, -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sel;
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      sel = 2'($urandom_range(0, 3));
      a   = $urandom;
      d   = $urandom;
      if (sel[1]) a[1:0] = 2'b00;
      else if (sel == 2'b01 && a[1:0] == 2'b11) a[1:0] = 2'b10;
      model_store(sel, a, d);
      total_cnt++;
      if ({req_ready, done} !== {1'b1, (i > 0)})
        $display("FAIL b2b%0d accept: got rdy=%b done=%b want 1 %b", i, req_ready, done, (i > 0));
      else pass_cnt++;
      req_valid = 1'b1; storesel = sel; addr = a; data = d; mem_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      total_cnt++;
      if ({mem_valid, mem_addr, mem_wdata, mem_be, busy} !==
          {1'b1, exp_addr[0], exp_wdata[0], exp_be[0], 1'b1})
        $display("FAIL b2b%0d beat: got v=%b a=%h d=%h be=%b want v=1 a=%h d=%h be=%b",
                 i, mem_valid, mem_addr, mem_wdata, mem_be, exp_addr[0], exp_wdata[0], exp_be[0]);
      else pass_cnt++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    total_cnt++;
    if ({done, req_ready} !== 2'b11)
      $display("FAIL b2b_last_done: got done=%b rdy=%b want 1 1", done, req_ready);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_misaligned_reject();
    nm_req_valid = 1'b1; nm_storesel = 2'b01; nm_addr = 32'h0000_1003; nm_data = 32'h0000_5A5A;
    total_cnt++;
    if (nm_req_ready !== 1'b1) $display("FAIL nm_ready: got %b want 1", nm_req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({nm_mem_valid, nm_mis, nm_req_ready, nm_busy, nm_done} !== 5'b01100)
      $display("FAIL nm_reject: got v=%b mis=%b rdy=%b busy=%b done=%b want 0 1 1 0 0",
               nm_mem_valid, nm_mis, nm_req_ready, nm_busy, nm_done);
    else pass_cnt++;
    nm_storesel = 2'b00; nm_addr = 32'h0000_1000; nm_data = 32'hAABB_CCDD;
    @(negedge clk);
    nm_req_valid = 1'b0;
    total_cnt++;
    if ({nm_mis, nm_mem_valid, nm_mem_addr, nm_mem_wdata, nm_mem_be} !==
        {1'b0, 1'b1, 32'h0000_1000, 32'h0000_00DD, 4'b0001})
      $display("FAIL nm_next_sb: got mis=%b v=%b a=%h d=%h be=%b want 0 1 00001000 000000dd 0001",
               nm_mis, nm_mem_valid, nm_mem_addr, nm_mem_wdata, nm_mem_be);
    else pass_cnt++;
    nm_mem_ready = 1'b1;
    @(negedge clk);
    nm_mem_ready = 1'b0;
    total_cnt++;
    if ({nm_done, nm_mem_valid, nm_mis} !== 3'b100)
      $display("FAIL nm_done: got done=%b v=%b mis=%b want 1 0 0", nm_done, nm_mem_valid, nm_mis);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_beat();
    req_valid = 1'b1; storesel = 2'b10; addr = 32'h0000_1002; data = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    total_cnt++;
    if ({mem_valid, mem_addr, mem_be} !== {1'b1, 32'h0000_1004, 4'b0011})
      $display("FAIL rst_mid_beat1: got v=%b a=%h be=%b want 1 00001004 0011", mem_valid, mem_addr, mem_be);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_valid, busy, done} !== 3'b000)
      $display("FAIL rst_mid_async: got v=%b busy=%b done=%b want 0 0 0", mem_valid, busy, done);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++;
    if ({req_ready, done, mem_valid} !== 3'b100)
      $display("FAIL rst_mid_release: got rdy=%b done=%b v=%b want 1 0 0", req_ready, done, mem_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, mem_valid} !== 2'b00)
      $display("FAIL rst_mid_no_done: got done=%b v=%b want 0 0", done, mem_valid);
    else pass_cnt++;
    do_store(2'b10, 32'h0000_3000, 32'hCAFE_F00D, 1, "after_reset");
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    req_valid = 1'b0; storesel = 2'b00; addr = '0; data = '0; mem_ready = 1'b0;
    nm_req_valid = 1'b0; nm_storesel = 2'b00; nm_addr = '0; nm_data = '0; nm_mem_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_misaligned_reject();
    test_reset_mid_beat();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
